// File: rtl/program_loader.sv
// Serial program loader: parses sync/count/data/checksum frames from a byte stream,
// writes 16-bit words into program memory and holds the CPU in reset until a good frame lands.
module program_loader #(
    parameter int          ADDR_WIDTH     = 11,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          RELEASE_CYCLES = 4
) (
    input  logic                  CLOCK_i,
    input  logic                  RESET_i,
    input  logic [7:0]            BYTE_i,
    input  logic                  BYTE_VALID_i,
    output logic                  BYTE_READY_o,
    output logic                  PMEM_WE_o,
    output logic [ADDR_WIDTH-1:0] PMEM_ADDR_o,
    output logic [15:0]           PMEM_DATA_o,
    output logic                  CPU_RESET_o,
    output logic                  DONE_o,
    output logic                  ERROR_o
);

    // state     | meaning
    // S_IDLE    | hunting for the sync byte
    // S_CNT_HI  | expecting word count high byte (only [2:0] legal)
    // S_CNT_LO  | expecting word count low byte
    // S_DATA_HI | expecting instruction high byte
    // S_DATA_LO | expecting instruction low byte
    // S_CHECK   | expecting checksum byte
    // S_RELEASE | good frame, counting down before releasing the CPU
    // S_RUN     | CPU running the loaded program
    // S_ERR     | malformed frame, waiting for a new sync byte
    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO,
        S_CHECK, S_RELEASE, S_RUN, S_ERR
    } state_t;

    localparam int TW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [2:0]            cnt_hi_q, cnt_hi_d;
    logic [10:0]           rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            hi_q, hi_d;
    logic [15:0]           data_q, data_d;
    logic                  we_q, we_d;
    logic [7:0]            sum_q, sum_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  accept;

    assign BYTE_READY_o = (state_q != S_RELEASE);
    assign accept       = BYTE_VALID_i && BYTE_READY_o;
    assign CPU_RESET_o  = (state_q != S_RUN);
    assign DONE_o       = (state_q == S_RUN);
    assign ERROR_o      = (state_q == S_ERR);
    assign PMEM_WE_o    = we_q;
    assign PMEM_ADDR_o  = addr_q;
    assign PMEM_DATA_o  = data_q;

    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        data_d   = data_q;
        we_d     = 1'b0;
        sum_d    = sum_q;
        tmr_d    = tmr_q;
        // Address advances in the cycle its write is presented.
        if (we_q) addr_d = addr_q + ADDR_WIDTH'(1);
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (accept && BYTE_i == SYNC_BYTE) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (accept) begin
                    if (BYTE_i[7:3] != 5'd0) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_hi_d = BYTE_i[2:0];
                        state_d  = S_CNT_LO;
                    end
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    rem_d   = {cnt_hi_q, BYTE_i};
                    addr_d  = '0;
                    sum_d   = 8'd0;
                    state_d = (rem_d == 11'd0) ? S_CHECK : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = BYTE_i;
                    sum_d   = sum_q + BYTE_i;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    data_d  = {hi_q, BYTE_i};
                    we_d    = 1'b1;
                    sum_d   = sum_q + BYTE_i;
                    rem_d   = rem_q - 11'd1;
                    state_d = (rem_q == 11'd1) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (BYTE_i == sum_q) begin
                        tmr_d   = TW'(RELEASE_CYCLES - 1);
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_RELEASE: begin
                if (tmr_q == '0) state_d = S_RUN;
                else             tmr_d   = tmr_q - TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_i) begin
        if (RESET_i) begin
            state_q  <= S_IDLE;
            cnt_hi_q <= 3'd0;
            rem_q    <= 11'd0;
            addr_q   <= '0;
            hi_q     <= 8'd0;
            data_q   <= 16'd0;
            we_q     <= 1'b0;
            sum_q    <= 8'd0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
            we_q     <= we_d;
            sum_q    <= sum_d;
            tmr_q    <= tmr_d;
        end
    end

endmodule
